ctrl_unit: RTL
==============

# ctrl_unit

Multicycle main control FSM for the MIPS datapath. It decodes the instruction register fields and the ALU status flags, then drives every select and write-enable of the datapath muxes, registers, memory and ALU. It covers fetch, decode, the R-type subset (add, sub, and, jr), addi, lw, sw, beq, bne and j, plus the invalid-opcode and overflow exception sequences. It is instantiated next to the datapath inside the CPU top level and shares its clock and reset.

## Interface
- No parameters; all encodings are fixed below.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- OPCODE  in  6  IR[31:26].
- FUNCT  in  6  IR[5:0] (OFFSET[5:0]).
- zero  in  1  ALU result == 0.
- O  in  1  ALU signed overflow, combinational, same cycle as operands.
- iord  out  2  memory address select: 0 = PC, 1 = ALUOut, 2 = exception vector, 3 = ALU result.
- excpControl  out  2  vector select: 0 = 253 (invalid opcode), 1 = 254 (overflow).
- memWrite  out  1  memory write strobe.
- irWrite  out  1  instruction register load.
- mdrWrite  out  1  memory data register load.
- abWrite  out  1  A/B register load.
- regWrite  out  1  register bank write.
- srcWrite  out  3  destination register select: 0 = RT, 1 = RD, 2 = 29.
- srcData  out  4  write-data select: 0 = ALUOut, 1 = LS output, 8 = constant 227.
- aluSrcA  out  2  ALU operand A select: 0 = PC, 1 = A.
- aluSrcB  out  2  ALU operand B select: 0 = B, 1 = 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- aluControl  out  3  ALU operation: 000 = pass A, 001 = add, 010 = sub, 011 = and.
- aluOutControl  out  1  ALUOut register load.
- pcSource  out  3  next-PC select: 0 = ALU result, 1 = ALUOut, 2 = jump concat, 3 = LS output.
- pcWrite  out  1  PC load.
- epcControl  out  1  EPC load from ALU result.
- lsControl  out  2  load size: 0 = word, 2 = byte.
- ssControl  out  2  store size: 0 = word.
- shiftSrc, shiftAmt, srcRead, multControl, divControl  out  1 each  tied to 0 in this revision.
- shiftControl  out  3  tied to 0 in this revision.
- excpCtrl  out  2  tied to 0 in this revision.

## Operation
- All outputs are decoded from the state register. Exceptions: pcWrite in BRANCH, and the EXEC-state transitions, also depend on the zero and O inputs.
- Any output not listed for a state is 0.
- RESET: srcWrite=2, srcData=8, regWrite=1, so $sp is set to 227. Next state is FETCH.
- FETCH: iord=0, aluSrcA=0, aluSrcB=1, aluControl=add, pcSource=0, pcWrite=1. Next is FETCH_WAIT, then IR (irWrite=1).
- DECODE: abWrite=1, aluSrcA=0, aluSrcB=3, aluControl=add, aluOutControl=1. This precomputes the branch target.
- Dispatch on OPCODE:
  - 0x00, R-type:
    - FUNCT 0x20, 0x22 or 0x24 goes to R_EXEC: aluSrcA=1, aluSrcB=0, aluControl=add/sub/and, aluOutControl=1.
    - If O=1 and the funct is add or sub, go to EXC_EPC with cause latched as overflow.
    - Otherwise go to R_WB: srcWrite=1, srcData=0, regWrite=1.
    - FUNCT 0x08 goes to JR: aluSrcA=1, aluControl=pass, pcSource=0, pcWrite=1.
    - Any other funct is treated as an invalid opcode.
  - 0x08, addi: I_EXEC uses aluSrcB=2 and add. If O=1, go to overflow. Otherwise go to I_WB with srcWrite=0.
  - 0x23 / 0x2B: ADDR computes A + imm into ALUOut; overflow is ignored.
    - lw: LW_RD (iord=1), LW_WAIT, LW_MDR (mdrWrite=1), then LW_WB (srcData=1, lsControl=0, srcWrite=0, regWrite=1).
    - sw: SW (iord=1, memWrite=1, ssControl=0).
  - 0x04 / 0x05: BRANCH uses aluSrcA=1, aluSrcB=0 and sub. pcSource=1 and pcWrite = zero XOR (OPCODE==0x05).
  - 0x02: JUMP sets pcSource=2, pcWrite=1.
  - Any other opcode: cause is latched as invalid, then go to EXC_EPC.
- Exception sequence:
  - EXC_EPC: aluSrcA=0, aluSrcB=1, sub, epcControl=1. EPC receives PC-4, the faulting instruction's address.
  - EXC_RD: iord=2, excpControl=cause.
  - EXC_WAIT, then EXC_MDR (mdrWrite=1), then EXC_JMP (pcSource=3, lsControl=2, pcWrite=1).
- Every terminal state returns to FETCH.
- The cause register is 1 bit: 0 = invalid opcode, 1 = overflow. It is written only on an exception transition.

## Timing
- Asynchronous reset:
  - The state is forced to RESET, the cause register to 0, and every output to 0 while reset is high.
  - The $sp write happens on the first clock edge after reset deasserts.
- Memory read latency: data is valid 2 cycles after the address cycle. For example, FETCH then FETCH_WAIT, with data captured in the IR state.
- Cycle counts from FETCH to the next FETCH:
  - R-type: 6.
  - addi: 6.
  - lw: 9.
  - sw: 6.
  - beq/bne: 5.
  - j: 5.
  - jr: 5.
  - exception path: 4 + 5 = 9.
- Overflow in R_EXEC or I_EXEC never produces regWrite=1 for the faulting instruction.
- Reset asserted mid-instruction aborts it immediately; no memory or register write completes after reset is asserted.

## Test plan
- Reset held 3 cycles, then released: all outputs are 0 during reset. In the first cycle after release, regWrite=1, srcWrite=2, srcData=8. The next state is FETCH with pcWrite=1.
- add with O=0: the outputs follow the 6-cycle sequence, and R_WB has regWrite=1, srcWrite=1. With O=1: no regWrite. EXC_RD has excpControl=1, iord=2. EXC_JMP has pcSource=3, lsControl=2.
- lw (0x23): 9 cycles, with mdrWrite in cycle 8 and regWrite with srcData=1 in cycle 9. sw (0x2B): memWrite=1 for exactly one cycle, iord=1.
- beq with zero=1, then zero=0: pcWrite is 1, then 0, with pcSource=1. bne with the same stimuli: pcWrite is 0, then 1.
- OPCODE=0x3F: epcControl=1 in EXC_EPC, and excpControl=0 in EXC_RD. R-type with FUNCT=0x01 takes the same path.
- reset asserted during LW_WAIT: outputs drop to 0 in the same cycle. After release, the sequence restarts at RESET.

Source files
------------

// File: rtl/ctrl_unit_if.sv
// Control bundle between the multicycle MIPS control FSM (master) and the datapath (slave).
// Carries the decoded instruction fields and ALU flags in, and every datapath select/enable out.
interface ctrl_unit_if;
   logic [5:0] OPCODE;
   logic [5:0] FUNCT;
   logic       zero;
   logic       O;

   logic [1:0] iord;
   logic [1:0] excpControl;
   logic       memWrite;
   logic       irWrite;
   logic       mdrWrite;
   logic       abWrite;
   logic       regWrite;
   logic [2:0] srcWrite;
   logic [3:0] srcData;
   logic [1:0] aluSrcA;
   logic [1:0] aluSrcB;
   logic [2:0] aluControl;
   logic       aluOutControl;
   logic [2:0] pcSource;
   logic       pcWrite;
   logic       epcControl;
   logic [1:0] lsControl;
   logic [1:0] ssControl;
   logic       shiftSrc;
   logic       shiftAmt;
   logic       srcRead;
   logic       multControl;
   logic       divControl;
   logic [2:0] shiftControl;
   logic [1:0] excpCtrl;

   modport master (
      input  OPCODE, FUNCT, zero, O,
      output iord, excpControl, memWrite, irWrite, mdrWrite, abWrite, regWrite,
             srcWrite, srcData, aluSrcA, aluSrcB, aluControl, aluOutControl,
             pcSource, pcWrite, epcControl, lsControl, ssControl,
             shiftSrc, shiftAmt, srcRead, multControl, divControl,
             shiftControl, excpCtrl
   );

   modport slave (
      output OPCODE, FUNCT, zero, O,
      input  iord, excpControl, memWrite, irWrite, mdrWrite, abWrite, regWrite,
             srcWrite, srcData, aluSrcA, aluSrcB, aluControl, aluOutControl,
             pcSource, pcWrite, epcControl, lsControl, ssControl,
             shiftSrc, shiftAmt, srcRead, multControl, divControl,
             shiftControl, excpCtrl
   );
endinterface

// File: rtl/ctrl_unit.sv
// Multicycle main control FSM for the MIPS datapath: fetch, decode, R-type/addi/lw/sw/branch/jump
// execution and the invalid-opcode / overflow exception sequence.
module ctrl_unit (
   input  logic        clk,
   input  logic        reset,
   ctrl_unit_if.master bus
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;

   localparam logic CAUSE_INVALID  = 1'b0;
   localparam logic CAUSE_OVERFLOW = 1'b1;

   typedef enum logic [4:0] {
      S_RESET, S_FETCH, S_FETCH_WAIT, S_IR, S_DECODE,
      S_R_EXEC, S_R_WB, S_JR, S_I_EXEC, S_I_WB,
      S_ADDR, S_LW_RD, S_LW_WAIT, S_LW_MDR, S_LW_WB, S_SW,
      S_BRANCH, S_JUMP,
      S_EXC_EPC, S_EXC_RD, S_EXC_WAIT, S_EXC_MDR, S_EXC_JMP
   } state_t;

   state_t state_q, state_d;
   logic   cause_q, cause_d;

   logic isAluFunct;
   logic isArithFunct;

   assign isAluFunct   = (bus.FUNCT == FN_ADD) || (bus.FUNCT == FN_SUB) || (bus.FUNCT == FN_AND);
   assign isArithFunct = (bus.FUNCT == FN_ADD) || (bus.FUNCT == FN_SUB);

   // Next-state and exception-cause selection; the cause only changes on a transition into EXC_EPC.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         S_RESET:      state_d = S_FETCH;
         S_FETCH:      state_d = S_FETCH_WAIT;
         S_FETCH_WAIT: state_d = S_IR;
         S_IR:         state_d = S_DECODE;
         S_DECODE: begin
            case (bus.OPCODE)
               OP_RTYPE: begin
                  if (isAluFunct) begin
                     state_d = S_R_EXEC;
                  end else if (bus.FUNCT == FN_JR) begin
                     state_d = S_JR;
                  end else begin
                     state_d = S_EXC_EPC;
                     cause_d = CAUSE_INVALID;
                  end
               end
               OP_ADDI:       state_d = S_I_EXEC;
               OP_LW, OP_SW:  state_d = S_ADDR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_J:          state_d = S_JUMP;
               default: begin
                  state_d = S_EXC_EPC;
                  cause_d = CAUSE_INVALID;
               end
            endcase
         end
         S_R_EXEC: begin
            if (bus.O && isArithFunct) begin
               state_d = S_EXC_EPC;
               cause_d = CAUSE_OVERFLOW;
            end else begin
               state_d = S_R_WB;
            end
         end
         S_I_EXEC: begin
            if (bus.O) begin
               state_d = S_EXC_EPC;
               cause_d = CAUSE_OVERFLOW;
            end else begin
               state_d = S_I_WB;
            end
         end
         S_ADDR:     state_d = (bus.OPCODE == OP_LW) ? S_LW_RD : S_SW;
         S_LW_RD:    state_d = S_LW_WAIT;
         S_LW_WAIT:  state_d = S_LW_MDR;
         S_LW_MDR:   state_d = S_LW_WB;
         S_EXC_EPC:  state_d = S_EXC_RD;
         S_EXC_RD:   state_d = S_EXC_WAIT;
         S_EXC_WAIT: state_d = S_EXC_MDR;
         S_EXC_MDR:  state_d = S_EXC_JMP;
         S_R_WB, S_I_WB, S_JR, S_LW_WB, S_SW, S_BRANCH, S_JUMP, S_EXC_JMP:
                     state_d = S_FETCH;
         default:    state_d = S_RESET;
      endcase
   end

   // State and cause registers; reset parks the FSM in RESET so the $sp init runs once released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RESET;
         cause_q <= CAUSE_INVALID;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

   // Moore decode of the datapath controls; reset level blanks everything so no write can slip out.
   always_comb begin
      bus.iord          = 2'd0;
      bus.excpControl   = 2'd0;
      bus.memWrite      = 1'b0;
      bus.irWrite       = 1'b0;
      bus.mdrWrite      = 1'b0;
      bus.abWrite       = 1'b0;
      bus.regWrite      = 1'b0;
      bus.srcWrite      = 3'd0;
      bus.srcData       = 4'd0;
      bus.aluSrcA       = 2'd0;
      bus.aluSrcB       = 2'd0;
      bus.aluControl    = ALU_PASS;
      bus.aluOutControl = 1'b0;
      bus.pcSource      = 3'd0;
      bus.pcWrite       = 1'b0;
      bus.epcControl    = 1'b0;
      bus.lsControl     = 2'd0;
      bus.ssControl     = 2'd0;
      if (!reset) begin
         case (state_q)
            S_RESET: begin
               bus.srcWrite = 3'd2;
               bus.srcData  = 4'd8;
               bus.regWrite = 1'b1;
            end
            S_FETCH: begin
               bus.iord       = 2'd0;
               bus.aluSrcA    = 2'd0;
               bus.aluSrcB    = 2'd1;
               bus.aluControl = ALU_ADD;
               bus.pcSource   = 3'd0;
               bus.pcWrite    = 1'b1;
            end
            S_IR: bus.irWrite = 1'b1;
            S_DECODE: begin
               bus.abWrite       = 1'b1;
               bus.aluSrcA       = 2'd0;
               bus.aluSrcB       = 2'd3;
               bus.aluControl    = ALU_ADD;
               bus.aluOutControl = 1'b1;
            end
            S_R_EXEC: begin
               bus.aluSrcA       = 2'd1;
               bus.aluSrcB       = 2'd0;
               bus.aluOutControl = 1'b1;
               case (bus.FUNCT)
                  FN_SUB:  bus.aluControl = ALU_SUB;
                  FN_AND:  bus.aluControl = ALU_AND;
                  default: bus.aluControl = ALU_ADD;
               endcase
            end
            S_R_WB: begin
               bus.srcWrite = 3'd1;
               bus.srcData  = 4'd0;
               bus.regWrite = 1'b1;
            end
            S_JR: begin
               bus.aluSrcA    = 2'd1;
               bus.aluControl = ALU_PASS;
               bus.pcSource   = 3'd0;
               bus.pcWrite    = 1'b1;
            end
            S_I_EXEC, S_ADDR: begin
               bus.aluSrcA       = 2'd1;
               bus.aluSrcB       = 2'd2;
               bus.aluControl    = ALU_ADD;
               bus.aluOutControl = 1'b1;
            end
            S_I_WB: begin
               bus.srcWrite = 3'd0;
               bus.srcData  = 4'd0;
               bus.regWrite = 1'b1;
            end
            S_LW_RD:  bus.iord = 2'd1;
            S_LW_MDR: bus.mdrWrite = 1'b1;
            S_LW_WB: begin
               bus.srcData   = 4'd1;
               bus.lsControl = 2'd0;
               bus.srcWrite  = 3'd0;
               bus.regWrite  = 1'b1;
            end
            S_SW: begin
               bus.iord      = 2'd1;
               bus.memWrite  = 1'b1;
               bus.ssControl = 2'd0;
            end
            S_BRANCH: begin
               bus.aluSrcA    = 2'd1;
               bus.aluSrcB    = 2'd0;
               bus.aluControl = ALU_SUB;
               bus.pcSource   = 3'd1;
               bus.pcWrite    = bus.zero ^ (bus.OPCODE == OP_BNE);
            end
            S_JUMP: begin
               bus.pcSource = 3'd2;
               bus.pcWrite  = 1'b1;
            end
            // PC already points past the faulting instruction, so subtracting 4 recovers its address.
            S_EXC_EPC: begin
               bus.aluSrcA    = 2'd0;
               bus.aluSrcB    = 2'd1;
               bus.aluControl = ALU_SUB;
               bus.epcControl = 1'b1;
            end
            S_EXC_RD: begin
               bus.iord        = 2'd2;
               bus.excpControl = {1'b0, cause_q};
            end
            S_EXC_MDR: bus.mdrWrite = 1'b1;
            S_EXC_JMP: begin
               bus.pcSource  = 3'd3;
               bus.lsControl = 2'd2;
               bus.pcWrite   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Shift, multiply/divide and extended exception controls are unused in this revision.
   assign bus.shiftSrc     = 1'b0;
   assign bus.shiftAmt     = 1'b0;
   assign bus.srcRead      = 1'b0;
   assign bus.multControl  = 1'b0;
   assign bus.divControl   = 1'b0;
   assign bus.shiftControl = 3'd0;
   assign bus.excpCtrl     = 2'd0;

endmodule
